level1b_mk3_map: RTL and testbench
==================================

LEVEL1B_MK3_MAP -- requirements
Module: level1b_mk3_map

Interface
REQ-001 SHALL have parameter PAGEREG_SZ, default 4, ROM page register width (1..4); ROM remap mask width is 2**PAGEREG_SZ.
REQ-002 SHALL have parameter IO_DELAY, default 5, bus cycles of low-speed hold after an FE4x access (1..15).
REQ-003 SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 hsclk  in  1  sole clock; all flops rise on it.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cyc_stb  in  1  one-hsclk pulse per CPU bus cycle; address, bank, status valid.
REQ-007 wr_stb  in  1  one-hsclk pulse; cpu_wdata valid for the write cycle last strobed.
REQ-008 cpu_adr  in  16  CPU address.
REQ-009 cpu_bank  in  8  CPU bank byte (data bus during phi1).
REQ-010 cpu_rnw, cpu_vpa, cpu_vda, cpu_vpb, cpu_e  in  1 each  65816 status.
REQ-011 cpu_wdata  in  8  write data.
REQ-012 hs_ack / ls_ack  in  1 each  clock switcher confirms hsclk / BBC clock in use.
REQ-013 hs_req  out  1  request high-speed CPU clock.
REQ-014 bank_q  out  8  remapped high address, held until next cyc_stb.
REQ-015 ram_ceb  out  1  on-board RAM select, active low.
REQ-016 dummy_access  out  1  BBC bus forced to dummy read.
REQ-017 reg_rd  out  1 / reg_rdata  out  8  internal register read active / data.
REQ-018 map_q  out  7 / pagereg_q  out  PAGEREG_SZ  register contents.

Function
REQ-019 SHALL register on cyc_stb: bank_q, cycle valid (vpa|vda), sync (vpa&vda), rnw, register select; all other times hold.
REQ-020 Remap to FE: bank[7]=0 and adr[15]=0; or bank[7]=0, map_q[5]=1, valid, and either adr in C000-FBFF or (adr[15:14]=10 and rom_mask[pagereg_q]=1); otherwise bank_q = cpu_bank.
REQ-021 Register space: bank[7:6]=10, vda; adr[1:0]=0 rom_mask[7:0], 1 rom_mask[15:8] (reads 0 / ignored beyond mask width), 3 map_q; 2 reads 0.
REQ-022 Register writes commit on wr_stb with registered select and rnw=0; reads drive reg_rd=1, reg_rdata one hsclk after cyc_stb.
REQ-023 Page register shadow: bank[7]=0, adr=FE30, write, wr_stb -> pagereg_q <= cpu_wdata[PAGEREG_SZ-1:0].
REQ-024 IO counter: cyc_stb with bank[7]=0, adr[15:4]=FE4, vda loads IO_DELAY; else each cyc_stb decrements if nonzero; no wrap below 0.
REQ-025 Clock FSM LS, TO_HS, HS, TO_LS; hs_req=1 in TO_HS and HS only.
REQ-026 LS->TO_HS when map_q[2]=1, registered sync, bank_q[7]=1, IO counter 0.
REQ-027 TO_HS->HS on hs_ack; TO_LS->LS on ls_ack; acks ignored in other states.
REQ-028 HS->TO_LS when map_q[2]=0, IO counter nonzero, or valid cycle with bank_q[7]=0.
REQ-029 TO_HS with map_q[2] cleared SHALL still wait hs_ack, then go TO_LS next cycle.
REQ-030 dummy_access = (valid & bank_q[7]) | state != LS; ram_ceb = !(valid & bank_q[6]).
REQ-031 cyc_stb and wr_stb coincident: write applies to previously registered cycle before new decode.

Reset
REQ-032 rst SHALL force: FSM LS, hs_req 0, map_q 0, pagereg_q 0, rom_mask only top bit set, IO counter 0, bank_q 00, ram_ceb 1, dummy_access 0, reg_rd 0, reg_rdata 0.
REQ-033 rst mid-handshake SHALL abandon it; pending acks after release are ignored.

Configuration
REQ-034 Macro REMAP_NATIVE_INTERRUPTS_EN: defined -> cyc_stb with cpu_vpb=0 and cpu_e=0 forces bank_q=FF, overriding REQ-020; undefined -> vpb/e ignored, bank_q per REQ-020.

Verification
REQ-035 map_q=04, sync fetch bank FF -> hs_req 1 next hsclk; hs_ack -> HS; fetch bank 00 -> hs_req 0, TO_LS; ls_ack -> LS.
REQ-036 Read FE40 from HS, IO_DELAY=5 -> TO_LS; LS persists 5 subsequent cycles; sixth FF sync fetch -> hs_req 1.
REQ-037 Write 0F to FE30, map_q=20, rom_mask reset -> read 00:8123 gives bank_q FE; pagereg 0E -> bank_q 00.
REQ-038 Write 55 to 80:0003 -> map_q 55, readback 55; write rom_mask 34/12 -> readback 34, 12.
REQ-039 rst asserted in TO_HS, then hs_ack -> FSM LS, hs_req 0, all REQ-032 values.
REQ-040 Native interrupt vector fetch (vpb 0, e 0, bank 00): with macro bank_q FF, without bank_q FE.

Source files
------------

// File: rtl/level1b_mk3_map_if.sv
// rtl/level1b_mk3_map_if.sv - CPU bus strobes, address, bank, status and write data
interface level1b_mk3_map_if;
  logic        cyc_stb;
  logic        wr_stb;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_bank;
  logic        cpu_rnw;
  logic        cpu_vpa;
  logic        cpu_vda;
  logic        cpu_vpb;
  logic        cpu_e;
  logic [7:0]  cpu_wdata;

  modport master (
    output cyc_stb, wr_stb, cpu_adr, cpu_bank, cpu_rnw,
    output cpu_vpa, cpu_vda, cpu_vpb, cpu_e, cpu_wdata
  );

  modport slave (
    input cyc_stb, wr_stb, cpu_adr, cpu_bank, cpu_rnw,
    input cpu_vpa, cpu_vda, cpu_vpb, cpu_e, cpu_wdata
  );
endinterface

// File: rtl/level1b_mk3_map.sv
// rtl/level1b_mk3_map.sv - Level 1b mk3 bank remapper, register file and CPU clock switch FSM
// Optional feature macro: REMAP_NATIVE_INTERRUPTS_EN (native-mode vector fetches forced to bank FF)
module level1b_mk3_map #(
  parameter int PAGEREG_SZ = 4,
  parameter int IO_DELAY   = 5
) (
  input  logic                  hsclk,
  input  logic                  rst,
  level1b_mk3_map_if.slave      bus,
  input  logic                  hs_ack,
  input  logic                  ls_ack,
  output logic                  hs_req,
  output logic [7:0]            bank_q,
  output logic                  ram_ceb,
  output logic                  dummy_access,
  output logic                  reg_rd,
  output logic [7:0]            reg_rdata,
  output logic [6:0]            map_q,
  output logic [PAGEREG_SZ-1:0] pagereg_q
);

  localparam int MASK_W = 2 ** PAGEREG_SZ;

  typedef enum logic [1:0] {ST_LS, ST_TO_HS, ST_HS, ST_TO_LS} clk_state_t;

  clk_state_t            state_q, state_d;
  logic                  valid_q, sync_q, rnw_q, regsel_q, pgw_q, io_idle_q;
  logic [1:0]            regadr_q;
  logic [3:0]            io_cnt_q, io_cnt_d;
  logic [MASK_W-1:0]     rom_mask_q, rom_mask_d;
  logic [6:0]            map_d;
  logic [PAGEREG_SZ-1:0] pagereg_d;
  logic [15:0]           mask_wr, mask_rd;
  logic [7:0]            bank_d, rdata_d;
  logic                  valid_now, low_half, in_os, in_rom, remap;
  logic                  regsel_d, pgw_d, io_hit;
  logic                  unused_status;

  assign unused_status = &{1'b0, bus.cpu_vpb, bus.cpu_e};

  // Register writes act on the cycle registered earlier, so a coincident
  // cyc_stb decodes against the freshly written values.
  always_comb begin
    map_d     = map_q;
    pagereg_d = pagereg_q;
    mask_wr   = '0;
    mask_wr[MASK_W-1:0] = rom_mask_q;
    if (bus.wr_stb && !rnw_q) begin
      if (regsel_q) begin
        case (regadr_q)
          2'd0:    mask_wr[7:0]  = bus.cpu_wdata;
          2'd1:    mask_wr[15:8] = bus.cpu_wdata;
          2'd3:    map_d         = bus.cpu_wdata[6:0];
          default: ;
        endcase
      end
      if (pgw_q) pagereg_d = bus.cpu_wdata[PAGEREG_SZ-1:0];
    end
    rom_mask_d = mask_wr[MASK_W-1:0];
    mask_rd    = '0;
    mask_rd[MASK_W-1:0] = rom_mask_d;
  end

  always_comb begin
    valid_now = bus.cpu_vpa | bus.cpu_vda;
    low_half  = !bus.cpu_bank[7];
    in_os     = (bus.cpu_adr >= 16'hC000) && (bus.cpu_adr <= 16'hFBFF);
    in_rom    = (bus.cpu_adr[15:14] == 2'b10) && rom_mask_d[pagereg_d];
    remap     = low_half && (!bus.cpu_adr[15] ||
                             (map_d[5] && valid_now && (in_os || in_rom)));
    bank_d    = remap ? 8'hFE : bus.cpu_bank;
`ifdef REMAP_NATIVE_INTERRUPTS_EN
    if (!bus.cpu_vpb && !bus.cpu_e) bank_d = 8'hFF;
`endif
    regsel_d  = (bus.cpu_bank[7:6] == 2'b10) && bus.cpu_vda;
    pgw_d     = low_half && (bus.cpu_adr == 16'hFE30);
    io_hit    = low_half && (bus.cpu_adr[15:4] == 12'hFE4) && bus.cpu_vda;
    if (io_hit)                io_cnt_d = 4'(IO_DELAY);
    else if (io_cnt_q != 4'd0) io_cnt_d = io_cnt_q - 4'd1;
    else                       io_cnt_d = 4'd0;
    case (bus.cpu_adr[1:0])
      2'd0:    rdata_d = mask_rd[7:0];
      2'd1:    rdata_d = mask_rd[15:8];
      2'd3:    rdata_d = {1'b0, map_d};
      default: rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      map_q      <= '0;
      pagereg_q  <= '0;
      rom_mask_q <= {1'b1, {(MASK_W-1){1'b0}}};
      bank_q     <= 8'h00;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      rnw_q      <= 1'b1;
      regsel_q   <= 1'b0;
      regadr_q   <= 2'd0;
      pgw_q      <= 1'b0;
      io_cnt_q   <= 4'd0;
      io_idle_q  <= 1'b1;
      reg_rd     <= 1'b0;
      reg_rdata  <= 8'h00;
    end else begin
      map_q      <= map_d;
      pagereg_q  <= pagereg_d;
      rom_mask_q <= rom_mask_d;
      if (bus.cyc_stb) begin
        bank_q    <= bank_d;
        valid_q   <= valid_now;
        sync_q    <= bus.cpu_vpa & bus.cpu_vda;
        rnw_q     <= bus.cpu_rnw;
        regsel_q  <= regsel_d;
        regadr_q  <= bus.cpu_adr[1:0];
        pgw_q     <= pgw_d;
        // The hold must have expired before this cycle began for it to
        // trigger a switch to high speed.
        io_idle_q <= (io_cnt_q == 4'd0);
        io_cnt_q  <= io_cnt_d;
        reg_rd    <= regsel_d & bus.cpu_rnw;
        reg_rdata <= (regsel_d & bus.cpu_rnw) ? rdata_d : 8'h00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LS:
        if (map_q[2] && sync_q && bank_q[7] && io_idle_q) state_d = ST_TO_HS;
      ST_TO_HS:
        if (hs_ack) state_d = map_q[2] ? ST_HS : ST_TO_LS;
      ST_HS:
        if (!map_q[2] || (io_cnt_q != 4'd0) || (valid_q && !bank_q[7]))
          state_d = ST_TO_LS;
      ST_TO_LS:
        if (ls_ack) state_d = ST_LS;
      default: state_d = ST_LS;
    endcase
  end

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LS;
      hs_req  <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_req  <= (state_d == ST_TO_HS) || (state_d == ST_HS);
    end
  end

  assign dummy_access = (valid_q & bank_q[7]) | (state_q != ST_LS);
  assign ram_ceb      = !(valid_q & bank_q[6]);

endmodule

// File: tb/tb_level1b_mk3_map.sv
// tb/tb_level1b_mk3_map.sv - self-checking bench for level1b_mk3_map
module tb_level1b_mk3_map;
  logic       hsclk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_ack = 1'b0, ls_ack = 1'b0;
  logic       hs_req, ram_ceb, dummy_access, reg_rd;
  logic [7:0] bank_q, reg_rdata;
  logic [6:0] map_q;
  logic [3:0] pagereg_q;
  int         errors = 0;
  int         checks = 0;

  logic [6:0]  m_map;
  logic [3:0]  m_pg;
  logic [15:0] m_mask;

  level1b_mk3_map_if bus ();

  level1b_mk3_map #(.PAGEREG_SZ(4), .IO_DELAY(5)) dut (
    .hsclk(hsclk), .rst(rst), .bus(bus), .hs_ack(hs_ack), .ls_ack(ls_ack),
    .hs_req(hs_req), .bank_q(bank_q), .ram_ceb(ram_ceb),
    .dummy_access(dummy_access), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .map_q(map_q), .pagereg_q(pagereg_q)
  );

  always #5 hsclk = ~hsclk;

  function automatic logic [7:0] exp_bank(input logic [7:0] b, input logic [15:0] a,
                                          input logic valid, input logic vpb, input logic e);
`ifdef REMAP_NATIVE_INTERRUPTS_EN
    if (!vpb && !e) return 8'hFF;
`else
    if (vpb === 1'bx || e === 1'bx) return 8'hxx;
`endif
    if (b < 8'h80) begin
      if (a < 16'h8000) return 8'hFE;
      if (m_map[5] && valid) begin
        if (a >= 16'hC000 && a <= 16'hFBFF) return 8'hFE;
        if (a >= 16'h8000 && a < 16'hC000 && m_mask[m_pg]) return 8'hFE;
      end
    end
    return b;
  endfunction

  function automatic logic [7:0] exp_reg(input int r);
    if (r == 0) return m_mask[7:0];
    if (r == 1) return m_mask[15:8];
    if (r == 3) return {1'b0, m_map};
    return 8'h00;
  endfunction

  task automatic do_cycle(input logic [7:0] b, input logic [15:0] a, input logic rnw,
                          input logic vpa, input logic vda, input logic vpb, input logic e);
    @(negedge hsclk);
    bus.cpu_bank = b; bus.cpu_adr = a; bus.cpu_rnw = rnw;
    bus.cpu_vpa = vpa; bus.cpu_vda = vda; bus.cpu_vpb = vpb; bus.cpu_e = e;
    bus.cyc_stb = 1'b1;
    @(negedge hsclk);
    bus.cyc_stb = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    @(negedge hsclk);
    bus.wr_stb = 1'b1; bus.cpu_wdata = d;
    @(negedge hsclk);
    bus.wr_stb = 1'b0;
  endtask

  task automatic reg_write(input int r, input logic [7:0] d);
    do_cycle(8'h80, 16'(r), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    do_write(d);
    if (r == 0) m_mask[7:0] = d;
    if (r == 1) m_mask[15:8] = d;
    if (r == 3) m_map = d[6:0];
  endtask

  task automatic pg_write(input logic [7:0] d);
    do_cycle(8'h00, 16'hFE30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    do_write(d);
    m_pg = d[3:0];
  endtask

  task automatic pulse(input int which);
    @(negedge hsclk);
    if (which == 0) hs_ack = 1'b1; else ls_ack = 1'b1;
    @(negedge hsclk);
    hs_ack = 1'b0; ls_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge hsclk);
    rst = 1'b1;
    repeat (2) @(negedge hsclk);
    rst = 1'b0;
    m_map = 7'h00; m_pg = 4'h0; m_mask = 16'h8000;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({hs_req, bank_q, ram_ceb, dummy_access, reg_rd, reg_rdata, map_q, pagereg_q} !==
        {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: hs_req=%b bank=%h ceb=%b dummy=%b rd=%b rdata=%h map=%h pg=%h",
               hs_req, bank_q, ram_ceb, dummy_access, reg_rd, reg_rdata, map_q, pagereg_q);
    end
  endtask

  task automatic test_regs();
    logic [7:0] vals [4];
    apply_reset();
    reg_write(3, 8'h55);
    checks++;
    if (map_q !== 7'h55) begin errors++; $display("FAIL map_write: got %h want 55", map_q); end
    reg_write(0, 8'h34);
    reg_write(1, 8'h12);
    vals[0] = 8'h34; vals[1] = 8'h12; vals[2] = 8'h00; vals[3] = 8'h55;
    for (int r = 0; r < 4; r++) begin
      do_cycle(8'h80, 16'(r), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (reg_rd !== 1'b1 || reg_rdata !== vals[r] || reg_rdata !== exp_reg(r)) begin
        errors++;
        $display("FAIL reg_read%0d: rd=%b data=%h want rd=1 data=%h", r, reg_rd, reg_rdata, vals[r]);
      end
    end
  endtask

  task automatic test_rom_remap();
    apply_reset();
    pg_write(8'h0F);
    reg_write(3, 8'h20);
    do_cycle(8'h00, 16'h8123, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bank_q !== 8'hFE || pagereg_q !== 4'hF) begin
      errors++; $display("FAIL rom_remap_on: bank=%h pg=%h want FE F", bank_q, pagereg_q);
    end
    pg_write(8'h0E);
    do_cycle(8'h00, 16'h8123, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bank_q !== 8'h00 || pagereg_q !== 4'hE) begin
      errors++; $display("FAIL rom_remap_off: bank=%h pg=%h want 00 E", bank_q, pagereg_q);
    end
  endtask

  task automatic test_random_map();
    logic [7:0]  b, eb;
    logic [15:0] a;
    logic        vpa, vda, isreg;
    apply_reset();
    reg_write(3, 8'($urandom) & 8'hFB);
    reg_write(0, 8'($urandom));
    reg_write(1, 8'($urandom));
    pg_write(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if (i % 4 == 0) b = {2'b10, b[5:0]};
      a = 16'($urandom);
      vpa = 1'($urandom); vda = 1'($urandom);
      if (i % 8 == 0) reg_write(0, 8'($urandom));
      do_cycle(b, a, 1'b1, vpa, vda, 1'b1, 1'b1);
      eb = exp_bank(b, a, vpa | vda, 1'b1, 1'b1);
      isreg = (b >= 8'h80 && b < 8'hC0 && vda);
      checks++;
      if (bank_q !== eb || ram_ceb !== !((vpa | vda) && eb[6]) ||
          dummy_access !== ((vpa | vda) && eb[7]) || reg_rd !== isreg ||
          reg_rdata !== (isreg ? exp_reg(int'(a % 4)) : 8'h00)) begin
        errors++;
        $display("FAIL random_map[%0d] %h:%h: bank=%h ceb=%b dum=%b rd=%b data=%h want bank=%h",
                 i, b, a, bank_q, ram_ceb, dummy_access, reg_rd, reg_rdata, eb);
      end
    end
  endtask

  task automatic test_clock_switch();
    apply_reset();
    reg_write(3, 8'h04);
    do_cycle(8'hFF, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge hsclk);
    checks++;
    if (hs_req !== 1'b1) begin errors++; $display("FAIL to_hs_req: got %b want 1", hs_req); end
    pulse(0);
    do_cycle(8'h00, 16'h9000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (hs_req !== 1'b1) begin errors++; $display("FAIL hs_hold: got %b want 1", hs_req); end
    @(negedge hsclk);
    checks++;
    if (hs_req !== 1'b0 || dummy_access !== 1'b1) begin
      errors++; $display("FAIL to_ls: hs_req=%b dummy=%b want 0 1", hs_req, dummy_access);
    end
    pulse(1);
    checks++;
    if (dummy_access !== 1'b0 || hs_req !== 1'b0) begin
      errors++; $display("FAIL back_ls: dummy=%b hs_req=%b want 0 0", dummy_access, hs_req);
    end
  endtask

  task automatic test_io_delay();
    apply_reset();
    reg_write(3, 8'h04);
    do_cycle(8'hFF, 16'h1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge hsclk);
    pulse(0);
    do_cycle(8'h00, 16'hFE40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge hsclk);
    checks++;
    if (hs_req !== 1'b0) begin errors++; $display("FAIL io_to_ls: got %b want 0", hs_req); end
    pulse(1);
    for (int k = 1; k <= 6; k++) begin
      do_cycle(8'hFF, 16'h2000 + 16'(k), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge hsclk);
      @(negedge hsclk);
      checks++;
      if (hs_req !== (k == 6)) begin
        errors++; $display("FAIL io_hold_cycle%0d: hs_req=%b want %b", k, hs_req, k == 6);
      end
    end
  endtask

  task automatic test_reset_handshake();
    apply_reset();
    reg_write(3, 8'h04);
    pg_write(8'h07);
    do_cycle(8'hFF, 16'h1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge hsclk);
    checks++;
    if (hs_req !== 1'b1) begin errors++; $display("FAIL rst_hs_pre: got %b want 1", hs_req); end
    rst = 1'b1; hs_ack = 1'b1;
    repeat (2) @(negedge hsclk);
    rst = 1'b0;
    m_map = 7'h00; m_pg = 4'h0; m_mask = 16'h8000;
    @(negedge hsclk);
    hs_ack = 1'b0;
    @(negedge hsclk);
    checks++;
    if ({hs_req, bank_q, ram_ceb, dummy_access, reg_rd, reg_rdata, map_q, pagereg_q} !==
        {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 4'h0}) begin
      errors++;
      $display("FAIL rst_mid_hs: hs_req=%b bank=%h ceb=%b dummy=%b map=%h pg=%h",
               hs_req, bank_q, ram_ceb, dummy_access, map_q, pagereg_q);
    end
    for (int r = 0; r < 2; r++) begin
      do_cycle(8'h80, 16'(r), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (reg_rdata !== exp_reg(r) || hs_req !== 1'b0) begin
        errors++; $display("FAIL rst_mask%0d: data=%h want %h hs_req=%b", r, reg_rdata, exp_reg(r), hs_req);
      end
    end
  endtask

  task automatic test_native_irq();
    logic [7:0] want;
    apply_reset();
    do_cycle(8'h00, 16'h7FEE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef REMAP_NATIVE_INTERRUPTS_EN
    want = 8'hFF;
`else
    want = 8'hFE;
`endif
    checks++;
    if (bank_q !== want) begin errors++; $display("FAIL native_irq: got %h want %h", bank_q, want); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_cycle(8'h80, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge hsclk);
    bus.wr_stb = 1'b1; bus.cpu_wdata = 8'h20;
    bus.cyc_stb = 1'b1; bus.cpu_bank = 8'h00; bus.cpu_adr = 16'hC100;
    bus.cpu_rnw = 1'b1; bus.cpu_vpa = 1'b0; bus.cpu_vda = 1'b1;
    @(negedge hsclk);
    bus.wr_stb = 1'b0; bus.cyc_stb = 1'b0;
    checks++;
    if (bank_q !== 8'hFE || map_q !== 7'h20) begin
      errors++; $display("FAIL coincident_strobes: bank=%h map=%h want FE 20", bank_q, map_q);
    end
  endtask

  initial begin
    bus.cyc_stb = 1'b0; bus.wr_stb = 1'b0; bus.cpu_adr = 16'h0000; bus.cpu_bank = 8'h00;
    bus.cpu_rnw = 1'b1; bus.cpu_vpa = 1'b0; bus.cpu_vda = 1'b0; bus.cpu_vpb = 1'b1;
    bus.cpu_e = 1'b1; bus.cpu_wdata = 8'h00;
    m_map = 7'h00; m_pg = 4'h0; m_mask = 16'h8000;
    test_reset();
    test_regs();
    test_rom_remap();
    test_random_map();
    test_clock_switch();
    test_io_delay();
    test_reset_handshake();
    test_native_irq();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
